// File: rtl/accel_bus_responder_if.sv
// CPU accelerator bus: request/handshake from the CPU, read data and completion back from the responder.
interface accel_bus_responder_if;
   logic        accel_en;
   logic        bus_wr;
   logic [2:0]  acc_regaddr;
   logic [15:0] host_wdata;
   logic [15:0] bus_rdata;
   logic        bus_oe;
   logic        accel_done;

   modport master (
      output accel_en, bus_wr, acc_regaddr, host_wdata,
      input  bus_rdata, bus_oe, accel_done
   );

   modport slave (
      input  accel_en, bus_wr, acc_regaddr, host_wdata,
      output bus_rdata, bus_oe, accel_done
   );
endinterface

// File: rtl/accel_bus_responder.sv
// Accelerator-side bus responder: 8-entry register map plus a 2-stage signed 16x16 MAC engine.
// Read data and accel_done are registered and valid during the single RESP cycle.
module accel_bus_responder #(
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned CNT_W  = 8,
   parameter logic [15:0] ID_VAL = 16'hACC1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   accel_bus_responder_if.slave bus
);

   localparam int unsigned DW = 16;
   localparam int unsigned PW = 2 * DW;

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_STATUS  = 3'd1;
   localparam logic [2:0] A_OP_A    = 3'd2;
   localparam logic [2:0] A_OP_B    = 3'd3;
   localparam logic [2:0] A_ACC_LO  = 3'd4;
   localparam logic [2:0] A_ACC_HI  = 3'd5;
   localparam logic [2:0] A_ID      = 3'd6;
   localparam logic [2:0] A_SCRATCH = 3'd7;

   typedef enum logic [1:0] {IDLE, STALL, RESP, RELEASE} state_t;

   state_t            state_q, state_d;
   logic              req_rd_q;
   logic [2:0]        req_addr_q;
   logic [DW-1:0]     req_wdata_q;

   logic [DW-1:0]     op_a_q, op_b_q, scratch_q;
   logic              sat_en_q, ovf_q;
   logic [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]  mac_count_q;
   logic              mac_launch_q, prod_valid_q;
   logic [PW-1:0]     prod_q;

   logic              done_d, oe_d;
   logic [DW-1:0]     rdata_d;

   logic              busy_c, hazard_c, cur_rd_c, wr_commit_c, mac_ovf_c;
   logic [2:0]        cur_addr_c;
   logic [DW-1:0]     rd_mux_c;
   logic [PW-1:0]     prod_c;
   logic signed [ACC_W:0] sum_c;

   assign busy_c      = mac_launch_q | prod_valid_q;
   assign wr_commit_c = (state_q == RESP) && !req_rd_q;
   assign cur_rd_c    = (state_q == IDLE) ? bus.bus_wr : req_rd_q;
   assign cur_addr_c  = (state_q == IDLE) ? bus.acc_regaddr : req_addr_q;

   // Anything that would observe or disturb the in-flight MAC must wait for it to drain.
   assign hazard_c = busy_c &&
      (( bus.bus_wr && (bus.acc_regaddr == A_STATUS || bus.acc_regaddr == A_ACC_LO ||
                        bus.acc_regaddr == A_ACC_HI)) ||
       (!bus.bus_wr && (bus.acc_regaddr == A_OP_B ||
                        (bus.acc_regaddr == A_CTRL && bus.host_wdata[0]))));

   assign prod_c    = $signed({{DW{op_a_q[DW-1]}}, op_a_q}) * $signed({{DW{op_b_q[DW-1]}}, op_b_q});
   assign sum_c     = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'($signed(prod_q));
   assign mac_ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];

   always_comb begin
      rd_mux_c = '0;
      case (cur_addr_c)
         A_CTRL:    rd_mux_c = {14'd0, sat_en_q, 1'b0};
         A_STATUS:  rd_mux_c = {8'(mac_count_q), 6'd0, ovf_q, busy_c};
         A_OP_A:    rd_mux_c = op_a_q;
         A_OP_B:    rd_mux_c = op_b_q;
         A_ACC_LO:  rd_mux_c = acc_q[15:0];
         A_ACC_HI:  rd_mux_c = acc_q[31:16];
         A_ID:      rd_mux_c = ID_VAL;
         A_SCRATCH: rd_mux_c = scratch_q;
         default:   rd_mux_c = '0;
      endcase
   end

   // Next state; bus outputs are precomputed so they are registered into RESP.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      rdata_d = '0;
      case (state_q)
         IDLE:    if (bus.accel_en) state_d = hazard_c ? STALL : RESP;
         STALL:   if (!busy_c) state_d = RESP;
         RESP:    state_d = RELEASE;
         RELEASE: if (!bus.accel_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == RESP) begin
         done_d = 1'b1;
         if (cur_rd_c) begin
            oe_d    = 1'b1;
            rdata_d = rd_mux_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         req_rd_q       <= 1'b0;
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         bus.accel_done <= 1'b0;
         bus.bus_oe     <= 1'b0;
         bus.bus_rdata  <= '0;
      end else begin
         state_q        <= state_d;
         bus.accel_done <= done_d;
         bus.bus_oe     <= oe_d;
         bus.bus_rdata  <= rdata_d;
         if (state_q == IDLE && bus.accel_en) begin
            req_rd_q    <= bus.bus_wr;
            req_addr_q  <= bus.acc_regaddr;
            req_wdata_q <= bus.host_wdata;
         end
      end
   end

   // Register file and MAC pipeline; clr is ordered last so it wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a_q       <= '0;
         op_b_q       <= '0;
         scratch_q    <= '0;
         sat_en_q     <= 1'b0;
         ovf_q        <= 1'b0;
         acc_q        <= '0;
         mac_count_q  <= '0;
         mac_launch_q <= 1'b0;
         prod_valid_q <= 1'b0;
         prod_q       <= '0;
      end else begin
         mac_launch_q <= wr_commit_c && (req_addr_q == A_OP_B);
         prod_valid_q <= mac_launch_q;
         if (mac_launch_q) prod_q <= prod_c;

         if (prod_valid_q) begin
            if (mac_ovf_c) begin
               ovf_q <= 1'b1;
               if (sat_en_q)
                  acc_q <= sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
               else
                  acc_q <= sum_c[ACC_W-1:0];
            end else begin
               acc_q <= sum_c[ACC_W-1:0];
            end
            if (mac_count_q != {CNT_W{1'b1}}) mac_count_q <= mac_count_q + CNT_W'(1);
         end

         if (wr_commit_c) begin
            case (req_addr_q)
               A_CTRL: begin
                  sat_en_q <= req_wdata_q[1];
                  if (req_wdata_q[0]) begin
                     acc_q       <= '0;
                     mac_count_q <= '0;
                     ovf_q       <= 1'b0;
                  end
               end
               A_OP_A:    op_a_q    <= req_wdata_q;
               A_OP_B:    op_b_q    <= req_wdata_q;
               A_SCRATCH: scratch_q <= req_wdata_q;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_accel_bus_responder.sv
// Directed bench for accel_bus_responder: register map, MAC arithmetic, stall and reset corner cases.
module tb_accel_bus_responder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   accel_bus_responder_if bus ();

   accel_bus_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      bit        rd;
      bit [2:0]  addr;
      bit [15:0] wd;
      bit [15:0] exp;
      int        lat;
   } vec_t;

   vec_t vecs_a[$];
   vec_t vecs_b[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(bit rd, bit [2:0] addr, bit [15:0] wd, bit [15:0] exp, int lat);
      vec_t v;
      v.rd = rd; v.addr = addr; v.wd = wd; v.exp = exp; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full handshake; lat = edges from request to done (-1 on timeout).
   task automatic txn(input bit rd, input bit [2:0] addr, input bit [15:0] wd,
                      output logic [15:0] rdata, output logic oe, output int lat, output bit stray);
      int n = 0;
      stray = 1'b0;
      bus.accel_en = 1'b1; bus.bus_wr = rd; bus.acc_regaddr = addr; bus.host_wdata = wd;
      do begin
         @(posedge clk); #1;
         n++;
         if (!bus.accel_done && (bus.bus_oe || bus.bus_rdata != 16'h0)) stray = 1'b1;
      end while (!bus.accel_done && n < 50);
      lat   = bus.accel_done ? n : -1;
      rdata = bus.bus_rdata;
      oe    = bus.bus_oe;
      bus.accel_en = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.bus_oe || bus.accel_done) stray = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [15:0] rdata;
      logic        oe;
      int          lat;
      bit          stray;
      txn(v.rd, v.addr, v.wd, rdata, oe, lat, stray);
      chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
      chk({tag, "_oe"}, {31'd0, oe}, {31'd0, v.rd});
      chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, (v.rd ? v.exp : 16'h0)});
      chk({tag, "_quiet"}, {31'd0, stray}, 32'd0);
   endtask

   initial begin
      logic [15:0] rdata;
      logic        oe;
      int          lat, pulses, timeouts;
      bit          stray;

      // Reads: rd=1. Hazard accesses right after an OP_B write take 2 edges.
      vecs_a.push_back(mk(1, 3'd6, 16'h0000, 16'hACC1, 1));
      vecs_a.push_back(mk(0, 3'd7, 16'hBEEF, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd7, 16'h0000, 16'hBEEF, 1));
      vecs_a.push_back(mk(0, 3'd2, 16'h0003, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'hFFFC, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h000A, 16'h0000, 2));
      vecs_a.push_back(mk(1, 3'd4, 16'h0000, 16'h0012, 2));
      vecs_a.push_back(mk(1, 3'd5, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0200, 1));
      vecs_a.push_back(mk(0, 3'd0, 16'h0002, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd0, 16'h0000, 16'h0002, 1));
      vecs_a.push_back(mk(0, 3'd2, 16'h8000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 2));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 2));
      vecs_a.push_back(mk(1, 3'd4, 16'h0000, 16'hFFFF, 2));
      vecs_a.push_back(mk(1, 3'd5, 16'h0000, 16'h7FFF, 1));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0502, 1));
      vecs_a.push_back(mk(0, 3'd0, 16'h0001, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd0, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 2));
      vecs_a.push_back(mk(0, 3'd3, 16'h8000, 16'h0000, 2));
      vecs_a.push_back(mk(1, 3'd4, 16'h0000, 16'h0000, 2));
      vecs_a.push_back(mk(1, 3'd5, 16'h0000, 16'hC000, 1));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0302, 1));
      vecs_a.push_back(mk(0, 3'd0, 16'h0001, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd4, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd5, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd6, 16'h5555, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd6, 16'h0000, 16'hACC1, 1));
      vecs_a.push_back(mk(0, 3'd2, 16'h0001, 16'h0000, 1));
      vecs_a.push_back(mk(1, 3'd2, 16'h0000, 16'h0001, 1));
      vecs_a.push_back(mk(0, 3'd3, 16'h0000, 16'h0000, 1));
      vecs_a.push_back(mk(0, 3'd0, 16'h0001, 16'h0000, 2));
      vecs_a.push_back(mk(1, 3'd1, 16'h0000, 16'h0000, 1));

      vecs_b.push_back(mk(1, 3'd4, 16'h0000, 16'h0104, 2));
      vecs_b.push_back(mk(1, 3'd5, 16'h0000, 16'h0000, 1));
      vecs_b.push_back(mk(1, 3'd1, 16'h0000, 16'hFF00, 1));

      rst_n = 1'b0;
      bus.accel_en = 1'b0; bus.bus_wr = 1'b0; bus.acc_regaddr = 3'd0; bus.host_wdata = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", {31'd0, bus.accel_done}, 32'd0);
      chk("rst_oe", {31'd0, bus.bus_oe}, 32'd0);
      chk("rst_rdata", {16'd0, bus.bus_rdata}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs_a[i]) run_vec(vecs_a[i], $sformatf("a%0d", i));

      // Request held high long after done must complete only once.
      pulses = 0;
      bus.accel_en = 1'b1; bus.bus_wr = 1'b1; bus.acc_regaddr = 3'd7;
      repeat (7) begin
         @(posedge clk); #1;
         if (bus.accel_done) pulses++;
      end
      bus.accel_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("hold_pulses", 32'(pulses), 32'd1);

      timeouts = 0;
      for (int k = 0; k < 260; k++) begin
         txn(1'b0, 3'd3, 16'h0001, rdata, oe, lat, stray);
         if (lat < 1) timeouts++;
      end
      chk("mac260_timeouts", 32'(timeouts), 32'd0);

      foreach (vecs_b[i]) run_vec(vecs_b[i], $sformatf("b%0d", i));

      // Reset while stalled behind a MAC.
      txn(1'b0, 3'd3, 16'h0005, rdata, oe, lat, stray);
      bus.accel_en = 1'b1; bus.bus_wr = 1'b1; bus.acc_regaddr = 3'd4;
      @(posedge clk); #1;
      chk("stall_no_done", {31'd0, bus.accel_done}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      bus.accel_en = 1'b0;
      rst_n = 1'b1;
      pulses = 0;
      repeat (4) begin
         if (bus.accel_done || bus.bus_oe || bus.bus_rdata != 16'h0) pulses++;
         @(posedge clk); #1;
      end
      chk("stall_rst_quiet", 32'(pulses), 32'd0);
      run_vec(mk(1, 3'd4, 16'h0000, 16'h0000, 1), "stall_acc");
      run_vec(mk(1, 3'd1, 16'h0000, 16'h0000, 1), "stall_status");

      // Reset during the RESP cycle of a write.
      bus.accel_en = 1'b1; bus.bus_wr = 1'b0; bus.acc_regaddr = 3'd7; bus.host_wdata = 16'h1234;
      @(posedge clk); #1;
      chk("resp_done", {31'd0, bus.accel_done}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      bus.accel_en = 1'b0;
      rst_n = 1'b1;
      pulses = 0;
      repeat (4) begin
         if (bus.accel_done || bus.bus_oe || bus.bus_rdata != 16'h0) pulses++;
         @(posedge clk); #1;
      end
      chk("resp_rst_quiet", 32'(pulses), 32'd0);
      run_vec(mk(1, 3'd7, 16'h0000, 16'h0000, 1), "resp_scratch");
      run_vec(mk(1, 3'd6, 16'h0000, 16'hACC1, 1), "resp_id");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
